rv32_barrel_irq_ctrl: RTL and testbench
=======================================

// Module: rv32_barrel_irq_ctrl
// PURPOSE
//   Per-hart interrupt capture stage directly upstream of the barrel CSR file bank.
//   - Synchronises the asynchronous external, timer and IPI interrupt lines of every hart.
//   - Rising-edge detects them and holds each one as a sticky pending bit.
//   - Presents the pending bits of the hart currently in the CSR stage (hart_id_i) on single-bit outputs.
//   - Clears a pending bit when the CSR file acknowledges the trap for that hart and source.
// PARAMETERS
//   NUM_HARTS       8                    number of barrel harts
//   HART_CNT_WIDTH  $clog2(NUM_HARTS)    width of hart index
//   SYNC_STAGES     2                    flop stages in each async synchroniser, legal range >=2
// PORTS
//   clk             in   1               core clock; only clock in the block
//   rst             in   1               synchronous reset, active-high
//   irq_i           in   NUM_HARTS       external interrupt per hart (async)
//   time_irq_i      in   NUM_HARTS       timer interrupt per hart (async)
//   ipi_i           in   NUM_HARTS       inter-processor interrupt per hart (async)
//   mvu_irq_i       in   NUM_HARTS       MVU interrupt per hart (clk-synchronous, 1-cycle pulse)
//   hart_id_i       in   HART_CNT_WIDTH  hart currently in the CSR stage
//   irq_ack_i       in   1               CSR file took a trap for hart_id_i this cycle
//   ack_src_i       in   2               irq_src_t of the acknowledged source
//   irq_o           out  1               ext pending for hart_id_i
//   time_irq_o      out  1               timer pending for hart_id_i
//   ipi_o           out  1               IPI pending for hart_id_i
//   mvu_irq_o       out  1               MVU pending for hart_id_i
//   pending_any_o   out  NUM_HARTS       OR of the 4 pending bits, per hart (scheduler wake)
// BEHAVIOUR
//   - Reset (rst=1 at posedge clk):
//     - Clears all synchroniser flops, edge-history flops and pending bits.
//     - All outputs read 0 from the following cycle.
//     - rst overrides any set or ack in the same cycle.
//   - Async path (irq/time_irq/ipi):
//     - SYNC_STAGES-flop synchroniser, then rising-edge detect (sync & ~prev).
//     - A detected edge sets pend[src][h] at the next posedge.
//     - Input high before edge 0 -> pending visible after edge SYNC_STAGES (edge 2 at default).
//   - MVU path: no synchroniser; mvu_irq_i[h]=1 sets pend[MVU][h] at the next posedge.
//   - Level semantics:
//     - A line held high produces exactly one pending set per rising edge.
//     - A line high across reset release counts as a new edge.
//   - Set while already pending: no effect; nothing counts, nothing overflows.
//   - Ack: irq_ack_i=1 clears pend[ack_src_i][hart_id_i] at the next posedge.
//     - Acking a bit that is not pending is harmless.
//   - Same bit set and acked in the same cycle: set wins, bit stays 1 (no lost interrupt).
//   - Sets on other harts or sources are independent of any concurrent ack.
//   - Outputs irq_o..mvu_irq_o:
//     - Combinational mux of pend[*][hart_id_i] (zero latency w.r.t. hart_id_i).
//     - No source priority is applied here; the CSR file prioritises.
//   - hart_id_i >= NUM_HARTS (non-power-of-2 NUM_HARTS): outputs 0, ack ignored.
//   - pending_any_o[h]: combinational OR of the four pend bits of hart h.
// STRUCTURE
//   - Package rv32_barrel_pkg:
//     - typedef enum logic[1:0] irq_src_t {IRQ_SRC_EXT=0, IRQ_SRC_TIMER=1, IRQ_SRC_IPI=2, IRQ_SRC_MVU=3}.
//     - localparam NUM_IRQ_SRC=4.
//   - Sub-module rv32_sync_edge (SYNC_STAGES param, clk/rst, async_i -> rise_o):
//     - Synchroniser plus rising-edge detector.
//     - 3*NUM_HARTS instances in a generate loop.
//   - Pending storage: logic pend[NUM_IRQ_SRC][NUM_HARTS], one always_ff with set-over-clear.
// TESTING
//   1. Reset: drive all irq inputs 1 with rst=1 for 3 cycles -> all outputs 0 throughout.
//      Release rst -> pend[EXT/TIMER/IPI][*] set at edge SYNC_STAGES after release.
//   2. Latency and select: raise irq_i[3] at edge 0 with hart_id_i=3.
//      -> irq_o=0 through edge 1, irq_o=1 after edge 2; with hart_id_i=5, irq_o=0.
//   3. Sticky and ack:
//      - Pulse time_irq_i[1] for 1 cycle, then hold 0 -> time_irq_o=1 for hart 1 indefinitely.
//      - irq_ack_i=1, ack_src_i=TIMER, hart_id_i=1 -> time_irq_o=0 next cycle.
//   4. Set/clear collision: mvu_irq_i[0]=1 and ack (MVU, hart 0) in the same cycle with pend already 1.
//      -> mvu_irq_o stays 1.
//   5. Level hold: ipi_i[7] held high 20 cycles, acked at cycle 10 -> ipi_o=0 after the ack.
//      Drop and re-raise -> ipi_o=1 again after SYNC_STAGES edges.
//   6. Isolation: all 8 harts raise ext simultaneously, ack hart 4 only.
//      -> pending_any_o=8'hEF; other sources untouched.

Source files
------------

// File: rtl/rv32_barrel_pkg.sv
// Shared types for the barrel interrupt capture stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_barrel_pkg;

    localparam int NUM_IRQ_SRC = 4;

    // Encoding is shared with the CSR file's ack_src field; do not reorder.
    typedef enum logic [1:0] {
        IRQ_SRC_EXT   = 2'd0,
        IRQ_SRC_TIMER = 2'd1,
        IRQ_SRC_IPI   = 2'd2,
        IRQ_SRC_MVU   = 2'd3
    } irq_src_t;

endpackage

// File: rtl/rv32_barrel_irq_ctrl_if.sv
// Interrupt lines in, per-hart pending view out, for the barrel CSR stage.
// Latency: pending outputs are combinational on hart_id_i.
// Backpressure: none; ack is a single-cycle strobe, sets are never refused.
interface rv32_barrel_irq_ctrl_if
    import rv32_barrel_pkg::*;
#(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
);

    logic [NUM_HARTS-1:0]      irq_i;
    logic [NUM_HARTS-1:0]      time_irq_i;
    logic [NUM_HARTS-1:0]      ipi_i;
    logic [NUM_HARTS-1:0]      mvu_irq_i;
    logic [HART_CNT_WIDTH-1:0] hart_id_i;
    logic                      irq_ack_i;
    irq_src_t                  ack_src_i;

    logic                      irq_o;
    logic                      time_irq_o;
    logic                      ipi_o;
    logic                      mvu_irq_o;
    logic [NUM_HARTS-1:0]      pending_any_o;

    modport master (
        output irq_i, time_irq_i, ipi_i, mvu_irq_i, hart_id_i, irq_ack_i, ack_src_i,
        input  irq_o, time_irq_o, ipi_o, mvu_irq_o, pending_any_o
    );

    modport slave (
        input  irq_i, time_irq_i, ipi_i, mvu_irq_i, hart_id_i, irq_ack_i, ack_src_i,
        output irq_o, time_irq_o, ipi_o, mvu_irq_o, pending_any_o
    );

endinterface

// File: rtl/rv32_sync_edge.sv
// Synchronises one async line into clk and flags its rising edges.
// Latency: rise_o asserts SYNC_STAGES-1 edges after the line is first sampled high.
// Backpressure: none; one single-cycle rise_o per rising edge of the line.
module rv32_sync_edge #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the line through the synchroniser; remember the last synced value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset clears history so a line high across reset release reads as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rv32_barrel_irq_ctrl.sv
// Captures per-hart interrupts as sticky pending bits and shows the CSR-stage hart's.
// Latency: async sources SYNC_STAGES edges to pending, MVU 1 edge, outputs 0 cycles from hart_id_i.
// Backpressure: none; a set on an already-pending bit is absorbed, set beats a same-cycle ack.
module rv32_barrel_irq_ctrl
    import rv32_barrel_pkg::*;
#(
    parameter int NUM_HARTS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32_barrel_irq_ctrl_if.slave bus
);

    // Async lines packed in irq_src_t order: [0]=ext, [1]=timer, [2]=ipi.
    logic [2:0][NUM_HARTS-1:0] async_lines;
    logic [2:0][NUM_HARTS-1:0] rise_async;
    logic                      pend_q [NUM_IRQ_SRC][NUM_HARTS];
    logic                      pend_d [NUM_IRQ_SRC][NUM_HARTS];
    logic [NUM_HARTS-1:0]      pend_any;
    logic                      hart_ok;

    assign async_lines = {bus.ipi_i, bus.time_irq_i, bus.irq_i};

    for (genvar s = 0; s < 3; s++) begin : g_src
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
            rv32_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk     (clk),
                .rst     (rst),
                .async_i (async_lines[s][h]),
                .rise_o  (rise_async[s][h])
            );
        end
    end

    // Out-of-range hart ids (non-power-of-2 NUM_HARTS) see nothing and ack nothing.
    assign hart_ok = (int'(bus.hart_id_i) < NUM_HARTS);

    // Apply the ack first, then the sets, so a colliding set is never lost.
    always_comb begin
        pend_d = pend_q;
        if (bus.irq_ack_i && hart_ok) begin
            pend_d[bus.ack_src_i][bus.hart_id_i] = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (rise_async[s][h]) begin
                    pend_d[s][h] = 1'b1;
                end
            end
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (bus.mvu_irq_i[h]) begin
                pend_d[IRQ_SRC_MVU][h] = 1'b1;
            end
        end
    end

    // Pending storage; reset wins over any concurrent set or ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_IRQ_SRC; s++) begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    pend_q[s][h] <= 1'b0;
                end
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    // Scheduler wake: any source pending per hart.
    always_comb begin
        pend_any = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            pend_any[h] = pend_q[IRQ_SRC_EXT][h] | pend_q[IRQ_SRC_TIMER][h] |
                          pend_q[IRQ_SRC_IPI][h] | pend_q[IRQ_SRC_MVU][h];
        end
    end

    // No priority between sources here; the CSR file arbitrates.
    assign bus.irq_o         = hart_ok & pend_q[IRQ_SRC_EXT][bus.hart_id_i];
    assign bus.time_irq_o    = hart_ok & pend_q[IRQ_SRC_TIMER][bus.hart_id_i];
    assign bus.ipi_o         = hart_ok & pend_q[IRQ_SRC_IPI][bus.hart_id_i];
    assign bus.mvu_irq_o     = hart_ok & pend_q[IRQ_SRC_MVU][bus.hart_id_i];
    assign bus.pending_any_o = pend_any;

endmodule

// File: tb/tb_rv32_barrel_irq_ctrl.sv
// Directed bench for rv32_barrel_irq_ctrl with a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32_barrel_irq_ctrl;
    import rv32_barrel_pkg::*;

    localparam int NH = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    rv32_barrel_irq_ctrl_if #(.NUM_HARTS(NH)) bus ();

    rv32_barrel_irq_ctrl #(
        .NUM_HARTS   (NH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a line's value is seen by the pending logic SS edges late;
    // a pending bit is set when that delayed view goes 0->1, or by an MVU pulse.
    // hist[s][h][j] = line value sampled j+1 edges ago (0 while in reset).
    bit m_pend [4][NH];
    bit hist   [3][NH][SS+1];
    bit model_live = 1'b0;

    always @(posedge clk) begin
        logic [NH-1:0] lines [3];
        bit nxt [4][NH];
        lines[0] = bus.irq_i;
        lines[1] = bus.time_irq_i;
        lines[2] = bus.ipi_i;
        if (rst) begin
            for (int s = 0; s < 4; s++)
                for (int h = 0; h < NH; h++) m_pend[s][h] = 1'b0;
            for (int s = 0; s < 3; s++)
                for (int h = 0; h < NH; h++)
                    for (int j = 0; j <= SS; j++) hist[s][h][j] = 1'b0;
            model_live = 1'b1;
        end else begin
            nxt = m_pend;
            if (bus.irq_ack_i && int'(bus.hart_id_i) < NH)
                nxt[int'(bus.ack_src_i)][int'(bus.hart_id_i)] = 1'b0;
            for (int s = 0; s < 3; s++)
                for (int h = 0; h < NH; h++)
                    if (hist[s][h][SS-1] && !hist[s][h][SS]) nxt[s][h] = 1'b1;
            for (int h = 0; h < NH; h++)
                if (bus.mvu_irq_i[h]) nxt[3][h] = 1'b1;
            m_pend = nxt;
            for (int s = 0; s < 3; s++)
                for (int h = 0; h < NH; h++) begin
                    for (int j = SS; j > 0; j--) hist[s][h][j] = hist[s][h][j-1];
                    hist[s][h][0] = lines[s][h];
                end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (model_live) begin
            int hid;
            logic [NH-1:0] any_exp;
            hid = int'(bus.hart_id_i);
            for (int h = 0; h < NH; h++)
                any_exp[h] = m_pend[0][h] | m_pend[1][h] | m_pend[2][h] | m_pend[3][h];
            check("model_irq",  {31'd0, bus.irq_o},      {31'd0, m_pend[0][hid]});
            check("model_time", {31'd0, bus.time_irq_o}, {31'd0, m_pend[1][hid]});
            check("model_ipi",  {31'd0, bus.ipi_o},      {31'd0, m_pend[2][hid]});
            check("model_mvu",  {31'd0, bus.mvu_irq_o},  {31'd0, m_pend[3][hid]});
            check("model_any",  {24'd0, bus.pending_any_o}, {24'd0, any_exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_hart(input string name, input logic [3:0] exp);
        settle();
        check(name, {28'd0, bus.irq_o, bus.time_irq_o, bus.ipi_o, bus.mvu_irq_o}, {28'd0, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.irq_i      = '1;
        bus.time_irq_i = '1;
        bus.ipi_i      = '1;
        bus.mvu_irq_i  = '0;
        bus.hart_id_i  = 3'd0;
        bus.irq_ack_i  = 1'b0;
        bus.ack_src_i  = IRQ_SRC_EXT;

        // 1: lines high through reset stay invisible, then appear SS edges after release.
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            check("t1_rst_any", {24'd0, bus.pending_any_o}, 32'h0);
            check("t1_rst_hart", {28'd0, bus.irq_o, bus.time_irq_o, bus.ipi_o, bus.mvu_irq_o}, 32'h0);
        end
        rst = 1'b0;
        tick(); settle(); check("t1_rel_e0", {24'd0, bus.pending_any_o}, 32'h0);
        tick(); settle(); check("t1_rel_e1", {24'd0, bus.pending_any_o}, 32'h0);
        tick(); settle(); check("t1_rel_e2", {24'd0, bus.pending_any_o}, 32'hFF);
        check_hart("t1_hart0", 4'b1110);
        bus.irq_i = '0; bus.time_irq_i = '0; bus.ipi_i = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("t1_rst_clear", {24'd0, bus.pending_any_o}, 32'h0);

        // 2: ext latency on hart 3 and hart select.
        bus.hart_id_i = 3'd3;
        tick();
        bus.irq_i[3] = 1'b1;
        tick(); check_hart("t2_e0", 4'b0000);
        tick(); check_hart("t2_e1", 4'b0000);
        tick(); check_hart("t2_e2", 4'b1000);
        bus.hart_id_i = 3'd5;
        check_hart("t2_hart5", 4'b0000);
        bus.hart_id_i = 3'd3;
        bus.irq_ack_i = 1'b1;
        bus.ack_src_i = IRQ_SRC_EXT;
        tick();
        bus.irq_ack_i = 1'b0;
        check_hart("t2_acked", 4'b0000);
        tick(); check_hart("t2_held_no_reset", 4'b0000);
        bus.irq_i[3] = 1'b0;

        // 3: one-cycle timer pulse is sticky until acked.
        bus.hart_id_i = 3'd1;
        bus.time_irq_i[1] = 1'b1;
        tick();
        bus.time_irq_i[1] = 1'b0;
        tick(); tick();
        repeat (5) tick();
        check_hart("t3_sticky", 4'b0100);
        bus.irq_ack_i = 1'b1;
        bus.ack_src_i = IRQ_SRC_TIMER;
        tick();
        bus.irq_ack_i = 1'b0;
        check_hart("t3_acked", 4'b0000);

        // 4: MVU set and ack colliding on an already-pending bit.
        bus.hart_id_i = 3'd0;
        bus.mvu_irq_i[0] = 1'b1;
        tick();
        bus.mvu_irq_i[0] = 1'b0;
        check_hart("t4_mvu_set", 4'b0001);
        bus.mvu_irq_i[0] = 1'b1;
        bus.irq_ack_i = 1'b1;
        bus.ack_src_i = IRQ_SRC_MVU;
        tick();
        bus.mvu_irq_i[0] = 1'b0;
        bus.irq_ack_i = 1'b0;
        check_hart("t4_set_wins", 4'b0001);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        check_hart("t4_ack_only", 4'b0000);

        // 5: IPI level held 20 cycles on hart 7, acked at cycle 10, then re-raised.
        bus.hart_id_i = 3'd7;
        bus.ack_src_i = IRQ_SRC_IPI;
        bus.ipi_i[7] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            bus.irq_ack_i = (c == 10);
            tick();
            check_hart("t5_hold", (c >= 3 && c <= 9) ? 4'b0010 : 4'b0000);
        end
        bus.irq_ack_i = 1'b0;
        bus.ipi_i[7] = 1'b0;
        repeat (3) tick();
        bus.ipi_i[7] = 1'b1;
        tick(); check_hart("t5_re_e0", 4'b0000);
        tick(); check_hart("t5_re_e1", 4'b0000);
        tick(); check_hart("t5_re_e2", 4'b0010);
        bus.ipi_i[7] = 1'b0;

        // 6: all harts raise ext, only hart 4 acked; MVU on hart 2 untouched.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.hart_id_i = 3'd2;
        bus.mvu_irq_i[2] = 1'b1;
        bus.irq_i = '1;
        tick();
        bus.mvu_irq_i[2] = 1'b0;
        tick(); tick();
        settle();
        check("t6_all", {24'd0, bus.pending_any_o}, 32'hFF);
        bus.hart_id_i = 3'd4;
        bus.irq_ack_i = 1'b1;
        bus.ack_src_i = IRQ_SRC_EXT;
        tick();
        bus.irq_ack_i = 1'b0;
        settle();
        check("t6_ack4", {24'd0, bus.pending_any_o}, 32'hEF);
        check_hart("t6_hart4", 4'b0000);
        bus.hart_id_i = 3'd2;
        check_hart("t6_hart2", 4'b1001);
        tick(); settle();
        check("t6_stable", {24'd0, bus.pending_any_o}, 32'hEF);
        bus.irq_i = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
